// File: rtl/instr_encoder_pkg.sv
// Shared types and field layout for the instruction encoder and any future
// assembler-side checkers that must agree on the 32-bit instruction format.
package instr_encoder_pkg;

  localparam int REG_W  = 5;
  localparam int WORD_W = 32;

  localparam int OP_LSB    = 0;
  localparam int F3_LSB    = 3;
  localparam int RD_LSB    = 6;
  localparam int RS1_LSB   = 11;
  localparam int RS2_LSB   = 16;
  localparam int F11_LSB   = 21;
  localparam int IMM16_LSB = 16;
  localparam int IMM21_LSB = 11;

  typedef enum logic [2:0] {
    OP_A = 3'b000,
    OP_B = 3'b001,
    OP_C = 3'b010,
    OP_D = 3'b011,
    OP_E = 3'b100,
    OP_F = 3'b101,
    OP_G = 3'b110,
    OP_H = 3'b111
  } op_t;

  typedef enum logic [2:0] {
    D_CLIR = 3'b000,
    D_CUIR = 3'b001,
    D_JLL  = 3'b010
  } func3_d_t;

  typedef enum logic [2:0] {
    F_IMM = 3'b000,
    F_MEM = 3'b001
  } func3_f_t;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'b00,
    ERR_OP    = 2'b01,
    ERR_RANGE = 2'b10,
    ERR_ALIGN = 2'b11
  } err_code_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DRAIN,
    ST_ERR
  } state_t;

  // True when imm is representable as a two's-complement value of 'width' bits.
  function automatic logic fits_signed(input logic [31:0] imm, input int unsigned width);
    logic [31:0] hi;
    hi = $signed(imm) >>> (width - 1);
    return (hi == '0) || (hi == '1);
  endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational field packer: decoded fields in, 32-bit instruction word out,
// together with a legality flag and the reason when the bundle is rejected.
module instr_pack
  import instr_encoder_pkg::*;
(
  input  logic [2:0]        op_i,
  input  logic [2:0]        func3_i,
  input  logic [10:0]       func11_i,
  input  logic [REG_W-1:0]  rd_i,
  input  logic [REG_W-1:0]  rs1_i,
  input  logic [REG_W-1:0]  rs2_i,
  input  logic [31:0]       imm_i,
  output logic [WORD_W-1:0] word_o,
  output logic              legal_o,
  output err_code_t         err_code_o
);

  logic range_ok;

  // NOTE: every output gets a default before the case so no path can infer a latch.
  always_comb begin
    word_o     = '0;
    legal_o    = 1'b1;
    err_code_o = ERR_NONE;
    range_ok   = 1'b1;

    word_o[OP_LSB +: 3] = op_i;
    word_o[F3_LSB +: 3] = func3_i;

    case (op_t'(op_i))
      OP_A: begin
        word_o[RD_LSB  +: REG_W] = rd_i;
        word_o[RS1_LSB +: REG_W] = rs1_i;
        word_o[RS2_LSB +: REG_W] = rs2_i;
        word_o[F11_LSB +: 11]    = func11_i;
      end
      OP_B, OP_F: begin
        word_o[RD_LSB    +: REG_W] = rd_i;
        word_o[RS1_LSB   +: REG_W] = rs1_i;
        word_o[IMM16_LSB +: 16]    = imm_i[15:0];
        // Only B with func3[2] set takes a zero-extended immediate.
        if (op_t'(op_i) == OP_B && func3_i[2]) range_ok = (imm_i[31:16] == '0);
        else                                   range_ok = fits_signed(imm_i, 16);
      end
      OP_C: begin
        word_o[RS1_LSB +: REG_W] = rs1_i;
        word_o[RS2_LSB +: REG_W] = rs2_i;
        word_o[RD_LSB  +: REG_W] = imm_i[4:0];
        word_o[F11_LSB +: 11]    = imm_i[15:5];
        range_ok = fits_signed(imm_i, 16);
      end
      OP_D: begin
        word_o[RD_LSB +: REG_W] = rd_i;
        if (func3_i == D_CUIR) begin
          word_o[IMM21_LSB +: 21] = imm_i[31:11];
          range_ok = (imm_i[10:0] == '0);
        end else begin
          word_o[IMM21_LSB +: 21] = imm_i[20:0];
          range_ok = fits_signed(imm_i, 21);
        end
      end
      OP_G: begin
        word_o[RS1_LSB +: REG_W] = rs1_i;
        word_o[RS2_LSB +: REG_W] = rs2_i;
        word_o[RD_LSB  +: REG_W] = imm_i[6:2];
        word_o[F11_LSB +: 11]    = imm_i[17:7];
        range_ok = fits_signed(imm_i, 18);
        if (imm_i[1:0] != 2'b00) begin
          legal_o    = 1'b0;
          err_code_o = ERR_ALIGN;
        end
      end
      default: begin
        legal_o    = 1'b0;
        err_code_o = ERR_OP;
      end
    endcase

    if (legal_o && !range_ok) begin
      legal_o    = 1'b0;
      err_code_o = ERR_RANGE;
    end
  end

endmodule

// File: rtl/instr_encoder.sv
// Streaming instruction encoder: accepts decoded field bundles during a bounded
// load session and writes packed words to consecutive imem addresses.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] num_words,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [2:0]        in_func3,
  input  logic [10:0]       in_func11,
  input  logic [REG_W-1:0]  in_rd,
  input  logic [REG_W-1:0]  in_rs1,
  input  logic [REG_W-1:0]  in_rs2,
  input  logic [31:0]       in_imm,
  output logic              imem_we,
  input  logic              imem_ready,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] rem_q, rem_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              err_q, err_d;
  err_code_t         code_q, code_d;
  logic              done_q, done_d;

  logic [31:0] pk_word;
  logic        pk_legal;
  err_code_t   pk_code;
  logic        out_free;
  logic        accept;

  instr_pack u_pack (
    .op_i       (in_op),
    .func3_i    (in_func3),
    .func11_i   (in_func11),
    .rd_i       (in_rd),
    .rs1_i      (in_rs1),
    .rs2_i      (in_rs2),
    .imm_i      (in_imm),
    .word_o     (pk_word),
    .legal_o    (pk_legal),
    .err_code_o (pk_code)
  );

  // The output slot is free when empty or when its word retires this cycle.
  assign out_free = !we_q || imem_ready;
  assign accept   = in_valid && in_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = (num_words == '0) ? ST_DRAIN : ST_LOAD;
      end
      ST_LOAD: begin
        if (accept) begin
          if (!pk_legal)                    state_d = ST_ERR;
          else if (rem_q == ADDR_W'(1))     state_d = ST_DRAIN;
        end
      end
      ST_DRAIN, ST_ERR: begin
        if (out_free) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state_q == ST_LOAD) && (rem_q != '0) && out_free;
    busy     = (state_q != ST_IDLE);
  end

  always_comb begin
    addr_d  = addr_q;
    rem_d   = rem_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    err_d   = err_q;
    code_d  = code_q;
    done_d  = 1'b0;

    if (we_q && imem_ready) we_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          addr_d = base_addr;
          rem_d  = num_words;
          err_d  = 1'b0;
          code_d = ERR_NONE;
        end
      end
      ST_LOAD: begin
        if (accept) begin
          if (pk_legal) begin
            we_d    = 1'b1;
            wdata_d = pk_word;
            waddr_d = addr_q;
            addr_d  = addr_q + 1'b1;
            rem_d   = rem_q - 1'b1;
          end else begin
            err_d  = 1'b1;
            code_d = pk_code;
          end
        end
      end
      ST_DRAIN: begin
        if (out_free) done_d = !err_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      rem_q   <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= ERR_NONE;
      done_q  <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      err_q   <= err_d;
      code_q  <= code_d;
      done_q  <= done_d;
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = waddr_q;
  assign imem_wdata = wdata_q;
  assign done       = done_q;
  assign err        = err_q;
  assign err_code   = code_q;

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Streaming instruction encoder for the instruction-memory loader. It is the inverse of the core decode path.
- Accepts decoded fields (op, func3, func11, register indices, full-width immediate) over a valid/ready handshake.
- Range-checks each immediate, packs the fields into a 32-bit instruction word, and writes it to the instruction-memory write port at consecutive word addresses.
- Sits between the debug/boot field source and the imem write port. It runs a bounded load session started by a pulse.

Parameters:
- ADDR_W, 12, imem word-address width.
- REG_W, 5, register-index width. Fixed by the format; no other value is legal.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- start  in  1  pulse; begin session (ignored unless IDLE)
- base_addr  in  ADDR_W  first word address, sampled on start
- num_words  in  ADDR_W  words in session, sampled on start
- in_valid  in  1  field bundle valid
- in_ready  out  1  field bundle accepted when in_valid&in_ready
- in_op  in  3  op type A..H (000..111)
- in_func3  in  3  subtype
- in_func11  in  11  type-A prefix; ignored otherwise
- in_rd, in_rs1, in_rs2  in  5 each  register indices
- in_imm  in  32  immediate as a full signed/unsigned value
- imem_we  out  1  write strobe; doubles as output valid
- imem_ready  in  1  imem accepts the write this cycle
- imem_addr  out  ADDR_W  word address
- imem_wdata  out  32  encoded instruction
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse: session completed with no error
- err  out  1  sticky; cleared on the next accepted start
- err_code  out  2  00 none, 01 illegal op (E/H), 10 immediate out of range, 11 misaligned G offset

Behaviour:
- Clock and reset: single clock clk. Reset is asynchronous and active-high, named rst.
- Reset values: state=IDLE; all outputs 0 (in_ready, imem_we, imem_addr, imem_wdata, busy, done, err, err_code).
- Encoding layout:
  - op at [2:0], func3 at [5:3], rd at [10:6], rs1 at [15:11], rs2 at [20:16], func11 at [31:21].
  - A: all fields as above.
  - B, F: rd, rs1; imm16 at [31:16].
  - C: rs1, rs2; imm[4:0] at [10:6], imm[15:5] at [31:21].
  - D: rd; imm21 at [31:11].
  - G: rs1, rs2; imm[6:2] at [10:6], imm[17:7] at [31:21].
  - Unused fields are 0.
- Immediate range rules:
  - B with func3[2]=1: 0..65535 (zero-extended).
  - B with func3[2]=0, C, F: -32768..32767.
  - D CLIR and JLL: signed 21-bit.
  - D CUIR (func3=001): in_imm[10:0] must be 0; field = in_imm[31:11].
  - G: signed 18-bit and in_imm[1:0]=0 (misaligned takes priority over range).
- FSM states: IDLE, LOAD, DRAIN, ERR.
  - IDLE + start: load addr=base_addr and remaining=num_words; clear err and err_code.
    - If num_words=0: go to DRAIN.
    - Otherwise: go to LOAD.
  - LOAD: in_ready = (remaining!=0) & (!imem_we | imem_ready).
    - On accept of a legal bundle: register wdata/addr, set imem_we next cycle (latency 1), addr+1 (wraps mod 2^ADDR_W), remaining-1.
    - When remaining reaches 0: go to DRAIN.
  - Illegal bundle: no write is issued. Set err and err_code, go to ERR. Any already-registered word still completes.
  - DRAIN: wait until !imem_we or (imem_we & imem_ready). Then pulse done (unless err) and go to IDLE.
  - ERR: behaves like DRAIN but done is never pulsed; returns to IDLE.
- imem_we/addr/wdata hold stable while imem_we & !imem_ready.
- Simultaneous output retire and input accept in one cycle is legal (full throughput, one word per cycle).
- start while busy is ignored.
- Reset mid-session: everything is cleared immediately and no partial write is reissued.

Decomposition:
- Shared package (core pkg): op_type enum, func3_d/func3_f enums, field bit-position constants, err_code enum.
- One sub-module: instr_pack. Purely combinational; fields -> word + legal + err_code. Shared with future assembler checks.

Test Plan:
- start base=0x010, n=1; A op=0 func3=0 rd=1 rs1=2 rs2=3 func11=0 -> imem_we at addr 0x010, wdata 0x00031040; done next cycle.
- B func3=000 rd=5 rs1=0 imm=-1 -> 0xFFFF0141. Same with imm=40000 -> err=1, err_code=10, no write, done never pulses.
- D CUIR rd=2 imm=0x12345800 -> 0x1234588B. imm=0x12345801 -> err_code=10.
- G func3=0 rs1=1 rs2=2 imm=-8 -> 0xFFE20F86. imm=-6 -> err_code=11. op=100 -> err_code=01.
- n=4 back-to-back, imem_ready low 3 cycles on word 2 -> in_ready low, outputs held, 4 writes at base..base+3 in order. base=0xFFF, n=2 -> addrs 0xFFF, 0x000.
- Assert rst mid-LOAD -> imem_we=0 and busy=0 immediately. num_words=0 start -> done pulse, no write.
